uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
- Parametrised UART receiver and the successor to the fixed 8N1 receiver.
- Configurable data width, parity and stop-bit count.
- Adds an input synchroniser, false-start rejection, parity/framing/overrun flags and a valid/ready output handshake with a one-word holding register.
- Sits between the board UART_RX pin and the core's input FIFO / loader logic.

Parameters:
- CLK_PER_HALF_BIT, 5208: clocks per half bit period. Full bit = 2*CLK_PER_HALF_BIT clocks. Must be >= 2.
- DATA_BITS, 8: data bits per frame, legal 5..9, transmitted LSB first.
- PARITY_EN, 0: 1 = a parity bit follows the data bits.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits, legal 1 or 2.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- UART_RX  in  1  serial line, idle high, asynchronous to clk
- rdata  out  DATA_BITS  received word, valid while valid=1
- valid  out  1  word available in holding register
- ready  in  1  consumer accepts word when valid&ready at a posedge
- perr  out  1  parity error for the word in rdata (0 when PARITY_EN=0)
- ferr  out  1  framing error (some stop bit sampled low) for the word in rdata
- overrun  out  1  sticky: an unconsumed word was overwritten; cleared on handshake
- busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset (rstn=0, asynchronous):
  - Synchroniser flops = 1; state=IDLE; counters=0.
  - rdata=0, valid=0, perr=0, ferr=0, overrun=0, busy=0.
  - Reset mid-frame abandons the frame; nothing is delivered.
- Synchroniser:
  - Two flops on UART_RX. All logic uses the second-stage output rx_s, which adds 2 cycles of latency.
- Bit counter:
  - Counts 0..2*CLK_PER_HALF_BIT-1 and wraps.
  - Cleared on every state transition, so sample points stay aligned to the detected start edge.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE:
  - rx_s=0 -> START, counter cleared.
- START:
  - Samples rx_s when counter = CLK_PER_HALF_BIT-1 (mid start bit).
  - rx_s=1 -> false start: back to IDLE, no output, no flags.
  - rx_s=0 -> DATA, counter cleared, bit index=0.
- DATA:
  - Samples rx_s when counter = 2*CLK_PER_HALF_BIT-1.
  - Shifts into shift register at index position (LSB first).
  - After DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
- PARITY:
  - Samples one bit at the same point.
  - perr_next = (XOR of data bits ^ parity bit) != PARITY_ODD.
  - Then -> STOP.
- STOP:
  - Samples STOP_BITS bits at full-bit intervals.
  - ferr_next = 1 if any stop sample = 0.
  - After the last stop sample: -> IDLE if that sample = 1; -> WAIT_HIGH if it = 0 (break / line stuck low).
- WAIT_HIGH:
  - Waits for rx_s=1, then -> IDLE. Prevents a held-low line being taken as a new start.
- Delivery:
  - On the cycle after the last stop sample: rdata, perr, ferr loaded and valid=1.
  - Frames with ferr or perr are still delivered; flags accompany the word.
  - Latency from the UART_RX start edge to valid=1 is 2 + CLK_PER_HALF_BIT + (DATA_BITS+PARITY_EN+STOP_BITS)*2*CLK_PER_HALF_BIT + 1 clocks (±1 for edge phase).
- Handshake:
  - valid&ready at a posedge -> valid=0 and overrun=0 next cycle, unless a new word loads in the same cycle.
  - rdata/perr/ferr stay stable while valid=1 and no new word loads.
  - ready is ignored while valid=0.
- Overrun / simultaneous events:
  - New word loads while valid=1 and ready=0: rdata and flags are overwritten, valid stays 1, overrun=1.
  - New word loads in the same cycle as a handshake: new word loaded, valid stays 1, overrun=0.
- Arithmetic: counters are sized with $clog2 of their maximum value; no wrap beyond the stated maximum.

Test Plan:
- Back-to-back frames: CLK_PER_HALF_BIT=4, default 8N1, ready=1; send 0xA5 then 0x3C -> two valid pulses with rdata=0xA5 then 0x3C, perr=0, ferr=0, overrun=0, each arriving at the latency formula value.
- False start: UART_RX low for 3 clocks (less than half bit) then high -> no valid, busy returns to 0, next good frame 0x5A received correctly.
- Parity: PARITY_EN=1, PARITY_ODD=0, DATA_BITS=7; send 0x41 with parity bit 0 -> rdata=0x41, perr=0. Send 0x41 with parity bit 1 -> perr=1, word still delivered.
- Framing/break: STOP_BITS=2, second stop bit driven 0, then line held low for 40 clocks -> ferr=1, state stays WAIT_HIGH with no second word; after the line goes high, frame 0x11 is received cleanly.
- Overrun: ready=0, send 0x01 then 0x02 -> rdata=0x02, overrun=1. Assert ready for one cycle -> valid=0, overrun=0. Handshake coinciding with a third word load -> valid stays 1, overrun=0.
- Reset mid-frame: rstn pulsed low during data bit 4 of 0xFF -> all outputs 0 immediately (asynchronous), no word delivered, next frame 0x80 received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with an input synchroniser,
// false-start rejection, parity/framing/overrun flags and a one-word
// holding register drained through a valid/ready handshake.
//
// Ports:
//   clk      system clock
//   rstn     asynchronous active-low reset
//   UART_RX  serial line, idle high, asynchronous to clk
//   rdata    received word, meaningful while valid=1
//   valid    holding register contains a word
//   ready    consumer takes the word when valid&ready at a posedge
//   perr     parity error for the word in rdata (0 without parity)
//   ferr     framing error (a stop bit sampled low) for the word in rdata
//   overrun  sticky: an unconsumed word was overwritten; cleared on handshake
//   busy     receiver is in any state other than IDLE
module uart_rx_param #(
    parameter int unsigned CLK_PER_HALF_BIT = 5208,
    parameter int unsigned DATA_BITS        = 8,
    parameter int unsigned PARITY_EN        = 0,
    parameter int unsigned PARITY_ODD       = 0,
    parameter int unsigned STOP_BITS        = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 UART_RX,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 valid,
    input  logic                 ready,
    output logic                 perr,
    output logic                 ferr,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned BIT_CLKS = 2 * CLK_PER_HALF_BIT;
    localparam int unsigned CNT_W    = $clog2(BIT_CLKS);
    localparam int unsigned IDX_W    = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLKS - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic             PAR_EN    = (PARITY_EN != 0);
    localparam logic             PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_meta, rx_s;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_acc_q, perr_acc_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic                 load_c;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= UART_RX;
            rx_s    <= rx_meta;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, sampling and frame accumulation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == BIT_LAST) ? '0 : cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        perr_acc_d = perr_acc_q;
        ferr_acc_d = ferr_acc_q;
        load_c     = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                // Mid start bit: a high line here was only a glitch.
                if (cnt_q == HALF_LAST) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = DATA;
                        idx_d      = '0;
                        perr_acc_d = 1'b0;
                        ferr_acc_d = 1'b0;
                    end
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    // Right-shift so the first (LSB) bit ends in bit 0.
                    shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = PAR_EN ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    perr_acc_d = ((^shreg_q) ^ rx_s) != PAR_ODD;
                    idx_d      = '0;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    if (!rx_s) begin
                        ferr_acc_d = 1'b1;
                    end
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        load_c  = 1'b1;
                        // A low final stop bit means break/stuck line.
                        state_d = rx_s ? IDLE : WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Re-align the bit timer to each state entry.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Frame datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            perr_acc_q <= 1'b0;
            ferr_acc_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            perr_acc_q <= perr_acc_d;
            ferr_acc_q <= ferr_acc_d;
        end
    end

    // Holding register and handshake; a load always wins over a drain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata   <= '0;
            valid   <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            overrun <= 1'b0;
            busy    <= 1'b0;
        end else begin
            busy <= (state_d != IDLE);
            if (load_c) begin
                rdata   <= shreg_q;
                perr    <= PAR_EN & perr_acc_q;
                ferr    <= ferr_acc_d;
                valid   <= 1'b1;
                overrun <= valid & ~ready;
            end else if (valid && ready) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed self-checking bench for uart_rx_param.
// dut_a is 8N1, dut_b is 7 data bits, even parity, 2 stop bits; both use
// CLK_PER_HALF_BIT=4 so a bit lasts 8 clocks.
module tb_uart_rx_param;

    localparam int CPH   = 4;
    localparam int BIT   = 2 * CPH;
    localparam int LAT_A = 2 + CPH + (8 + 0 + 1) * BIT + 1;
    localparam int LAT_B = 2 + CPH + (7 + 1 + 2) * BIT + 1;

    typedef struct {
        int         cyc;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } cap_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic       rx_a, rx_b, ready_a, ready_b;
    logic [7:0] rdata_a;
    logic [6:0] rdata_b;
    logic       valid_a, perr_a, ferr_a, overrun_a, busy_a;
    logic       valid_b, perr_b, ferr_b, overrun_b, busy_b;

    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    cap_t qa[$];
    cap_t qb[$];
    logic va_prev  = 1'b0;
    logic vb_prev  = 1'b0;
    cap_t ca, cb;

    uart_rx_param #(
        .CLK_PER_HALF_BIT(CPH), .DATA_BITS(8), .PARITY_EN(0),
        .PARITY_ODD(0), .STOP_BITS(1)
    ) dut_a (
        .clk(clk), .rstn(rstn), .UART_RX(rx_a), .rdata(rdata_a),
        .valid(valid_a), .ready(ready_a), .perr(perr_a), .ferr(ferr_a),
        .overrun(overrun_a), .busy(busy_a)
    );

    uart_rx_param #(
        .CLK_PER_HALF_BIT(CPH), .DATA_BITS(7), .PARITY_EN(1),
        .PARITY_ODD(0), .STOP_BITS(2)
    ) dut_b (
        .clk(clk), .rstn(rstn), .UART_RX(rx_b), .rdata(rdata_b),
        .valid(valid_b), .ready(ready_b), .perr(perr_b), .ferr(ferr_b),
        .overrun(overrun_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every rising edge of valid with its cycle number.
    always @(posedge clk) begin
        #1;
        if (valid_a && !va_prev) begin
            ca.cyc = cyc; ca.data = 9'(rdata_a);
            ca.perr = perr_a; ca.ferr = ferr_a; ca.ovr = overrun_a;
            qa.push_back(ca);
        end
        if (valid_b && !vb_prev) begin
            cb.cyc = cyc; cb.data = 9'(rdata_b);
            cb.perr = perr_b; cb.ferr = ferr_b; cb.ovr = overrun_b;
            qb.push_back(cb);
        end
        va_prev = valid_a;
        vb_prev = valid_b;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] frame_a(input logic [7:0] d);
        return {6'b0, 1'b1, d, 1'b0};
    endfunction

    function automatic logic [15:0] frame_b(input logic [6:0] d, input logic p, input logic s2);
        return {5'b0, s2, 1'b1, p, d, 1'b0};
    endfunction

    task automatic set_rx(input int which, input logic v);
        if (which == 0) rx_a = v;
        else rx_b = v;
    endtask

    // Call at a negedge; each bit is held for BIT clocks, LSB of bits first.
    task automatic drive_frame(input int which, input logic [15:0] bits, input int len, output int ts);
        ts = cyc;
        for (int i = 0; i < len; i++) begin
            set_rx(which, bits[i]);
            repeat (BIT) @(negedge clk);
        end
    endtask

    task automatic wait_q(input int which, input int n, input int budget);
        int k;
        k = 0;
        while (k < budget && ((which == 0) ? qa.size() : qb.size()) < n) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b0; ready_b = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rdata_a !== 8'h00) begin failures++; $display("FAIL reset_rdata_a got=%h exp=00", rdata_a); end
        checks++;
        if (valid_a !== 1'b0) begin failures++; $display("FAIL reset_valid_a got=%b exp=0", valid_a); end
        checks++;
        if ({perr_a, ferr_a, overrun_a, busy_a} !== 4'b0000)
            begin failures++; $display("FAIL reset_flags_a got=%b exp=0000", {perr_a, ferr_a, overrun_a, busy_a}); end
        checks++;
        if ({valid_b, perr_b, ferr_b, overrun_b, busy_b} !== 5'b00000)
            begin failures++; $display("FAIL reset_b got=%b exp=00000", {valid_b, perr_b, ferr_b, overrun_b, busy_b}); end
        rstn = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp [2];
        int         ts  [2];
        int         lat;
        exp[0] = 8'hA5; exp[1] = 8'h3C;
        ready_a = 1'b1;
        qa.delete();
        drive_frame(0, frame_a(exp[0]), 10, ts[0]);
        drive_frame(0, frame_a(exp[1]), 10, ts[1]);
        wait_q(0, 2, 200);
        checks++;
        if (qa.size() !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", qa.size()); end
        for (int i = 0; i < 2 && i < qa.size(); i++) begin
            checks++;
            if (qa[i].data !== {1'b0, exp[i]})
                begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, qa[i].data, exp[i]); end
            checks++;
            if ({qa[i].perr, qa[i].ferr, qa[i].ovr} !== 3'b000)
                begin failures++; $display("FAIL b2b_flags[%0d] got=%b exp=000", i, {qa[i].perr, qa[i].ferr, qa[i].ovr}); end
            lat = qa[i].cyc - ts[i];
            checks++;
            if (lat < LAT_A - 1 || lat > LAT_A + 1)
                begin failures++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", i, lat, LAT_A); end
        end
        repeat (5) @(negedge clk);
        checks++;
        if (valid_a !== 1'b0 || busy_a !== 1'b0)
            begin failures++; $display("FAIL b2b_idle got=%b%b exp=00", valid_a, busy_a); end
    endtask

    task automatic test_false_start;
        int ts;
        qa.delete();
        rx_a = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy_a !== 1'b1) begin failures++; $display("FAIL fs_busy_high got=%b exp=1", busy_a); end
        rx_a = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (busy_a !== 1'b0) begin failures++; $display("FAIL fs_busy_low got=%b exp=0", busy_a); end
        checks++;
        if (qa.size() !== 0) begin failures++; $display("FAIL fs_no_word got=%0d exp=0", qa.size()); end
        drive_frame(0, frame_a(8'h5A), 10, ts);
        wait_q(0, 1, 100);
        checks++;
        if (qa.size() !== 1) begin failures++; $display("FAIL fs_next_count got=%0d exp=1", qa.size()); end
        else if (qa[0].data !== 9'h05A || {qa[0].perr, qa[0].ferr} !== 2'b00)
            begin failures++; $display("FAIL fs_next_word got=%h/%b%b exp=5a/00", qa[0].data, qa[0].perr, qa[0].ferr); end
    endtask

    task automatic test_parity;
        int ts, lat;
        ready_b = 1'b1;
        qb.delete();
        drive_frame(1, frame_b(7'h41, 1'b0, 1'b1), 11, ts);
        wait_q(1, 1, 50);
        checks++;
        if (qb.size() !== 1) begin failures++; $display("FAIL par_good_count got=%0d exp=1", qb.size()); end
        else begin
            checks++;
            if (qb[0].data !== 9'h041 || {qb[0].perr, qb[0].ferr} !== 2'b00)
                begin failures++; $display("FAIL par_good got=%h/%b%b exp=41/00", qb[0].data, qb[0].perr, qb[0].ferr); end
            lat = qb[0].cyc - ts;
            checks++;
            if (lat < LAT_B - 1 || lat > LAT_B + 1)
                begin failures++; $display("FAIL par_latency got=%0d exp=%0d", lat, LAT_B); end
        end
        qb.delete();
        drive_frame(1, frame_b(7'h41, 1'b1, 1'b1), 11, ts);
        wait_q(1, 1, 50);
        checks++;
        if (qb.size() !== 1) begin failures++; $display("FAIL par_bad_count got=%0d exp=1", qb.size()); end
        else if (qb[0].data !== 9'h041 || {qb[0].perr, qb[0].ferr} !== 2'b10)
            begin failures++; $display("FAIL par_bad got=%h/%b%b exp=41/10", qb[0].data, qb[0].perr, qb[0].ferr); end
    endtask

    task automatic test_break;
        int ts;
        qb.delete();
        drive_frame(1, frame_b(7'h0F, 1'b0, 1'b0), 11, ts);
        repeat (40) @(negedge clk);
        checks++;
        if (qb.size() !== 1) begin failures++; $display("FAIL brk_count got=%0d exp=1", qb.size()); end
        else if (qb[0].data !== 9'h00F || {qb[0].perr, qb[0].ferr} !== 2'b01)
            begin failures++; $display("FAIL brk_word got=%h/%b%b exp=0f/01", qb[0].data, qb[0].perr, qb[0].ferr); end
        checks++;
        if (busy_b !== 1'b1) begin failures++; $display("FAIL brk_wait_high got=%b exp=1", busy_b); end
        rx_b = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy_b !== 1'b0) begin failures++; $display("FAIL brk_release got=%b exp=0", busy_b); end
        qb.delete();
        drive_frame(1, frame_b(7'h11, 1'b0, 1'b1), 11, ts);
        wait_q(1, 1, 50);
        checks++;
        if (qb.size() !== 1) begin failures++; $display("FAIL brk_next_count got=%0d exp=1", qb.size()); end
        else if (qb[0].data !== 9'h011 || {qb[0].perr, qb[0].ferr} !== 2'b00)
            begin failures++; $display("FAIL brk_next got=%h/%b%b exp=11/00", qb[0].data, qb[0].perr, qb[0].ferr); end
    endtask

    task automatic test_overrun;
        int ts;
        ready_a = 1'b0;
        drive_frame(0, frame_a(8'h01), 10, ts);
        drive_frame(0, frame_a(8'h02), 10, ts);
        repeat (3) @(negedge clk);
        checks++;
        if ({valid_a, overrun_a} !== 2'b11 || rdata_a !== 8'h02)
            begin failures++; $display("FAIL ovr_set got=v%b o%b d%h exp=v1 o1 d02", valid_a, overrun_a, rdata_a); end
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
        checks++;
        if ({valid_a, overrun_a} !== 2'b00)
            begin failures++; $display("FAIL ovr_drain got=v%b o%b exp=v0 o0", valid_a, overrun_a); end
        drive_frame(0, frame_a(8'h03), 10, ts);
        drive_frame(0, frame_a(8'h04), 10, ts);
        repeat (3) @(negedge clk);
        checks++;
        if ({valid_a, overrun_a} !== 2'b11 || rdata_a !== 8'h04)
            begin failures++; $display("FAIL ovr_set2 got=v%b o%b d%h exp=v1 o1 d04", valid_a, overrun_a, rdata_a); end
        // Handshake lands on the same edge that loads the next word.
        fork
            drive_frame(0, frame_a(8'h05), 10, ts);
            begin
                repeat (LAT_A - 1) @(negedge clk);
                ready_a = 1'b1;
                @(negedge clk);
                ready_a = 1'b0;
            end
        join
        checks++;
        if ({valid_a, overrun_a} !== 2'b10 || rdata_a !== 8'h05)
            begin failures++; $display("FAIL ovr_coincide got=v%b o%b d%h exp=v1 o0 d05", valid_a, overrun_a, rdata_a); end
        ready_a = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_midframe;
        int ts;
        ready_a = 1'b1;
        qa.delete();
        fork
            drive_frame(0, frame_a(8'hFF), 10, ts);
            begin
                repeat (44) @(negedge clk);
                checks++;
                if (busy_a !== 1'b1) begin failures++; $display("FAIL rst_mid_busy got=%b exp=1", busy_a); end
                rstn = 1'b0;
                #1;
                checks++;
                if (rdata_a !== 8'h00 || {valid_a, perr_a, ferr_a, overrun_a, busy_a} !== 5'b00000)
                    begin failures++; $display("FAIL rst_mid_async got=d%h %b exp=d00 00000", rdata_a, {valid_a, perr_a, ferr_a, overrun_a, busy_a}); end
                repeat (2) @(negedge clk);
                rstn = 1'b1;
            end
        join
        repeat (100) @(negedge clk);
        checks++;
        if (qa.size() !== 0) begin failures++; $display("FAIL rst_mid_no_word got=%0d exp=0", qa.size()); end
        drive_frame(0, frame_a(8'h80), 10, ts);
        wait_q(0, 1, 100);
        checks++;
        if (qa.size() !== 1) begin failures++; $display("FAIL rst_next_count got=%0d exp=1", qa.size()); end
        else if (qa[0].data !== 9'h080 || {qa[0].perr, qa[0].ferr, qa[0].ovr} !== 3'b000)
            begin failures++; $display("FAIL rst_next got=%h exp=80", qa[0].data); end
    endtask

    initial begin
        rstn = 1'b0; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b0; ready_b = 1'b0;
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_false_start();
        test_parity();
        test_break();
        test_overrun();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
